// File: rtl/demux_4x1_tdm_pkg.sv
// Shared constants for the 4-slot TDM receive demultiplexer.
package demux_4x1_tdm_pkg;

   // FSM state encoding: IDLE waits for a frame sync, RUN collects slots.
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Slot indices as seen on sel; they match the transmitter mux select.
   localparam logic [1:0] SLOT_A = 2'd0;
   localparam logic [1:0] SLOT_B = 2'd1;
   localparam logic [1:0] SLOT_C = 2'd2;
   localparam logic [1:0] SLOT_D = 2'd3;

   // Number of slots in one frame.
   localparam int FRAME_SLOTS = 4;

endpackage : demux_4x1_tdm_pkg

// File: rtl/demux_4x1_tdm_slot_counter_2b.sv
// 2-bit slot counter: synchronous clear, load-to-1 (frame start), increment.
module slot_counter_2b
   import demux_4x1_tdm_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       load1,
   input  logic       inc,
   output logic [1:0] cnt
);

   logic [1:0] cnt_q;
   logic [1:0] cnt_d;

   // Next count: clear wins over load, load wins over increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = SLOT_A;
      end else if (load1) begin
         cnt_d = SLOT_B;
      end else if (inc) begin
         cnt_d = cnt_q + 2'd1;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= SLOT_A;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule : slot_counter_2b

// File: rtl/demux_4x1_tdm.sv
// 1-to-4 time-division demultiplexer: collects four slot words after a
// frame sync and presents them in parallel with a one-cycle valid strobe.
module demux_4x1_tdm
   import demux_4x1_tdm_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic [WIDTH-1:0] in,
   output logic [1:0]       sel,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [WIDTH-1:0] out_c,
   output logic [WIDTH-1:0] out_d,
   output logic             frame_valid,
   output logic             busy,
   output logic             sync_err
);

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] s0_q, s0_d;
   logic [WIDTH-1:0] s1_q, s1_d;
   logic [WIDTH-1:0] s2_q, s2_d;
   logic [WIDTH-1:0] out_a_q, out_a_d;
   logic [WIDTH-1:0] out_b_q, out_b_d;
   logic [WIDTH-1:0] out_c_q, out_c_d;
   logic [WIDTH-1:0] out_d_q, out_d_d;
   logic             frame_valid_q, frame_valid_d;
   logic             sync_err_q, sync_err_d;

   logic [1:0] slot;
   logic       slot_clr;
   logic       slot_load1;
   logic       slot_inc;

   slot_counter_2b u_slot_counter (
      .clk   (clk),
      .rst   (rst),
      .clr   (slot_clr),
      .load1 (slot_load1),
      .inc   (slot_inc),
      .cnt   (slot)
   );

   // Frame FSM: shadow-register capture, parallel output update, resync detection.
   always_comb begin
      state_d       = state_q;
      s0_d          = s0_q;
      s1_d          = s1_q;
      s2_d          = s2_q;
      out_a_d       = out_a_q;
      out_b_d       = out_b_q;
      out_c_d       = out_c_q;
      out_d_d       = out_d_q;
      frame_valid_d = 1'b0;
      sync_err_d    = sync_err_q;
      slot_clr      = 1'b0;
      slot_load1    = 1'b0;
      slot_inc      = 1'b0;

      if (state_q == ST_IDLE) begin
         // A sync without an enable is not a sample and is ignored.
         if (en && sync) begin
            s0_d       = in;
            slot_load1 = 1'b1;
            state_d    = ST_RUN;
         end
      end else if (en) begin
         if (sync) begin
            // Resync: drop the partial frame and restart at slot 0.
            sync_err_d = 1'b1;
            s0_d       = in;
            slot_load1 = 1'b1;
         end else begin
            case (slot)
               SLOT_B: begin
                  s1_d     = in;
                  slot_inc = 1'b1;
               end
               SLOT_C: begin
                  s2_d     = in;
                  slot_inc = 1'b1;
               end
               SLOT_D: begin
                  out_a_d       = s0_q;
                  out_b_d       = s1_q;
                  out_c_d       = s2_q;
                  out_d_d       = in;
                  frame_valid_d = 1'b1;
                  slot_clr      = 1'b1;
                  state_d       = ST_IDLE;
               end
               default: begin
                  // Slot 0 never occurs in RUN; recover to IDLE if it does.
                  slot_clr = 1'b1;
                  state_d  = ST_IDLE;
               end
            endcase
         end
      end
   end

   // State and data registers; reset discards any partial frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         s0_q          <= '0;
         s1_q          <= '0;
         s2_q          <= '0;
         out_a_q       <= '0;
         out_b_q       <= '0;
         out_c_q       <= '0;
         out_d_q       <= '0;
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         s0_q          <= s0_d;
         s1_q          <= s1_d;
         s2_q          <= s2_d;
         out_a_q       <= out_a_d;
         out_b_q       <= out_b_d;
         out_c_q       <= out_c_d;
         out_d_q       <= out_d_d;
         frame_valid_q <= frame_valid_d;
         sync_err_q    <= sync_err_d;
      end
   end

   assign sel         = slot;
   assign busy        = (state_q == ST_RUN);
   assign out_a       = out_a_q;
   assign out_b       = out_b_q;
   assign out_c       = out_c_q;
   assign out_d       = out_d_q;
   assign frame_valid = frame_valid_q;
   assign sync_err    = sync_err_q;

endmodule : demux_4x1_tdm

// File: tb/tb_demux_4x1_tdm.sv
// Scoreboard bench for demux_4x1_tdm: stimulus pushes expected frames,
// a negedge monitor pops one per frame_valid pulse and compares.
module tb_demux_4x1_tdm;

   logic       clk;
   logic       rst;
   logic       en;
   logic       sync;
   logic [0:0] in;
   logic [1:0] sel;
   logic [0:0] out_a, out_b, out_c, out_d;
   logic       frame_valid;
   logic       busy;
   logic       sync_err;

   int tests;
   int fails;
   int cycle;
   logic [3:0] exp_q[$];

   demux_4x1_tdm #(.WIDTH(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .sync        (sync),
      .in          (in),
      .sel         (sel),
      .out_a       (out_a),
      .out_b       (out_b),
      .out_c       (out_c),
      .out_d       (out_d),
      .frame_valid (frame_valid),
      .busy        (busy),
      .sync_err    (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
      end else begin
         $display("[TB] ok   %s = %0h", name, act);
      end
   endtask

   // One clock with the given inputs; returns #1 after the edge.
   task automatic step(input logic e, input logic s, input logic i);
      en   = e;
      sync = s;
      in   = i;
      @(posedge clk);
      #1;
   endtask

   // Send a complete frame with en=1, checking sel before each sample.
   task automatic frame(input string name, input logic [3:0] w);
      chk({name, " sel0"}, sel, 2'd0);
      step(1'b1, 1'b1, w[3]);
      chk({name, " sel1"}, sel, 2'd1);
      step(1'b1, 1'b0, w[2]);
      chk({name, " sel2"}, sel, 2'd2);
      step(1'b1, 1'b0, w[1]);
      chk({name, " sel3"}, sel, 2'd3);
      exp_q.push_back(w);
      step(1'b1, 1'b0, w[0]);
      chk({name, " sel_end"}, sel, 2'd0);
   endtask

   // Monitor: every frame_valid pulse must match the oldest expected frame.
   always @(negedge clk) begin
      if (frame_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL frame_valid: unexpected pulse, out=%b%b%b%b required no pulse",
                     out_a, out_b, out_c, out_d);
         end else begin
            chk("frame out_abcd", {28'd0, out_a, out_b, out_c, out_d}, {28'd0, exp_q.pop_front()});
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: time limit reached, required normal completion");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

   initial begin
      tests = 0;
      fails = 0;
      cycle = 0;
      rst   = 1'b1;
      en    = 1'b1;
      sync  = 1'b1;
      in    = 1'b1;

      // Reset with all inputs active.
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst outs", {28'd0, out_a, out_b, out_c, out_d}, 32'd0);
      chk("rst sel", sel, 2'd0);
      chk("rst busy", busy, 1'b0);
      chk("rst fv", frame_valid, 1'b0);
      chk("rst err", sync_err, 1'b0);
      rst = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      chk("idle sync no en busy", busy, 1'b0);

      // Single frame 1,0,1,1.
      frame("single", 4'b1011);
      chk("single busy_after", busy, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("single hold out_a", out_a, 1'b1);

      // Stalled frame 1,0 | stall x3 | 1,1.
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b1, 1'b0);
         chk("stall sel", sel, 2'd2);
         chk("stall busy", busy, 1'b1);
         chk("stall fv", frame_valid, 1'b0);
      end
      step(1'b1, 1'b0, 1'b1);
      exp_q.push_back(4'b1011);
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);

      // Resync: 1,1 then sync at slot 2 with 0, then 0,1,0.
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      chk("resync pre err", sync_err, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("resync err", sync_err, 1'b1);
      chk("resync sel", sel, 2'd1);
      chk("resync busy", busy, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      exp_q.push_back(4'b0010);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("resync err sticky", sync_err, 1'b1);

      // Back-to-back frames; busy drops only in the gap cycle.
      frame("b2b f1", 4'b1000);
      chk("b2b busy gap", busy, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("b2b busy", busy, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      chk("b2b busy", busy, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      chk("b2b busy", busy, 1'b1);
      exp_q.push_back(4'b0111);
      step(1'b1, 1'b0, 1'b1);
      chk("b2b busy end", busy, 1'b0);
      step(1'b0, 1'b0, 1'b0);

      // Load 1,1,1,1, then reset mid-frame at slot 2.
      frame("pre-rst", 4'b1111);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk("midrst sel before", sel, 2'd2);
      rst = 1'b1;
      step(1'b1, 1'b0, 1'b1);
      rst = 1'b0;
      chk("midrst outs", {28'd0, out_a, out_b, out_c, out_d}, 32'd0);
      chk("midrst busy", busy, 1'b0);
      chk("midrst sel", sel, 2'd0);
      chk("midrst err", sync_err, 1'b0);
      frame("post-rst", 4'b0010);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);

      chk("scoreboard drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_demux_4x1_tdm
